// File: rtl/ri5cy_mem_arbiter.sv
// Two-master arbiter sharing one RI5CY req/gnt/rvalid memory port (m1 data over m0 fetch).
// Optional grant/stall statistics counters are enabled by defining RI5CY_MEM_ARB_STATS_EN.
module ri5cy_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
`ifdef RI5CY_MEM_ARB_STATS_EN
  ,
  output logic [31:0]             m0_grant_cnt_o,
  output logic [31:0]             m1_grant_cnt_o,
  output logic [31:0]             stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SC_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SC_W-1:0]  SC_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] DEPTH  = CNT_W'(MAX_OUTSTANDING);

  // Owner FIFO as a shift register: bit 0 is the oldest entry, 1 means m1 owns it.
  logic [MAX_OUTSTANDING-1:0] own_q, own_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SC_W-1:0]            starve_q;
  logic fifo_full, fifo_empty, force_m0, win_m1, grant, pop;

  assign fifo_full  = (cnt_q == DEPTH);
  assign fifo_empty = (cnt_q == '0);
  assign force_m0   = (STARVE_LIMIT > 0) && m0_req_i && (starve_q == SC_MAX);
  assign win_m1     = m1_req_i & ~force_m0;

  assign s_req_o  = (m0_req_i | m1_req_i) & ~fifo_full & ~rst;
  assign grant    = s_req_o & s_gnt_i;
  assign m0_gnt_o = grant & ~win_m1;
  assign m1_gnt_o = grant & win_m1;

  assign s_addr_o  = win_m1 ? m1_addr_i  : m0_addr_i;
  assign s_we_o    = win_m1 ? m1_we_i    : 1'b0;
  assign s_be_o    = win_m1 ? m1_be_i    : '1;
  assign s_wdata_o = win_m1 ? m1_wdata_i : '0;

  assign pop         = s_rvalid_i & ~fifo_empty & ~rst;
  assign m0_rvalid_o = pop & ~own_q[0];
  assign m1_rvalid_o = pop & own_q[0];
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  // New owner lands just behind the surviving entries after a same-cycle pop.
  always_comb begin
    own_d = own_q;
    if (pop) own_d = own_q >> 1;
    for (int i = 0; i < MAX_OUTSTANDING; i++)
      if (grant && (CNT_W'(i) == cnt_q - CNT_W'(pop))) own_d[i] = win_m1;
    cnt_d = cnt_q + CNT_W'(grant) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q    <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      err_o    <= 1'b0;
    end else begin
      own_q <= own_d;
      cnt_q <= cnt_d;
      if (s_rvalid_i && fifo_empty) err_o <= 1'b1;
      if (!m0_req_i || m0_gnt_o)
        starve_q <= '0;
      else if (m1_gnt_o && starve_q != SC_MAX)
        starve_q <= starve_q + 1'b1;
    end
  end

`ifdef RI5CY_MEM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_grant_cnt_o <= '0;
      m1_grant_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (m0_gnt_o) m0_grant_cnt_o <= m0_grant_cnt_o + 1'b1;
      if (m1_gnt_o) m1_grant_cnt_o <= m1_grant_cnt_o + 1'b1;
      if ((m0_req_i | m1_req_i) && !grant) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end
`endif

endmodule
